// File: rtl/fp7_alu_pkg.sv
// ----------------------------------------------------------------------------
// fp7_alu_pkg : shared defaults and types for the fp7 ALU and its result sink
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fp7_alu_pkg;

  localparam int ACCUM_DATA_WIDTH  = 32;
  localparam int EXPONENT_WIDTH    = 3;
  localparam int MANTISSA_WIDTH    = 3;
  localparam int RESULT_ADDR_WIDTH = 8;

  // Single source of truth for the ALU pipeline depth.
  localparam int FP7_ALU_LATENCY   = 4;

  typedef struct packed {
    logic [RESULT_ADDR_WIDTH-1:0] addr;
    logic [ACCUM_DATA_WIDTH-1:0]  data;
  } result_entry_t;

endpackage

`default_nettype wire

// File: rtl/fp7_result_fifo.sv
// ----------------------------------------------------------------------------
// fp7_result_fifo : synchronous show-ahead FIFO with occupancy count
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp7_result_fifo #(
  parameter  int WIDTH   = 40,
  parameter  int DEPTH   = 8,
  localparam int C_PTR_W = $clog2(DEPTH),
  localparam int C_CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic [C_CNT_W-1:0] count
);

  localparam logic [C_PTR_W-1:0] c_PTR_ONE = C_PTR_W'(1);
  localparam logic [C_CNT_W-1:0] c_CNT_ONE = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] c_FULL    = C_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign w_do_push = push && ((r_count != c_FULL) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  assign rd_data  = r_mem[r_rd_ptr];
  assign rd_valid = (r_count != '0);
  assign count    = r_count;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (r_count == c_FULL)));

endmodule

`default_nettype wire

// File: rtl/fp7_alu_result_sink.sv
// ----------------------------------------------------------------------------
// fp7_alu_result_sink : tracks ALU issue slots, buffers results, grants credit
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp7_alu_result_sink
  import fp7_alu_pkg::*;
#(
  parameter  int ACCUM_DATA_WIDTH = fp7_alu_pkg::ACCUM_DATA_WIDTH,
  parameter  int ADDR_WIDTH       = 8,
  parameter  int ALU_LATENCY      = FP7_ALU_LATENCY,
  parameter  int FIFO_DEPTH       = 8,
  localparam int C_INFL_W         = $clog2(ALU_LATENCY + 1),
  localparam int C_CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]       issue_addr_i,
  output logic                        issue_ready_o,
  input  logic [ACCUM_DATA_WIDTH-1:0] alu_data_i,
  output logic                        wr_valid_o,
  output logic [ADDR_WIDTH-1:0]       wr_addr_o,
  output logic [ACCUM_DATA_WIDTH-1:0] wr_data_o,
  input  logic                        wr_ready_i,
  output logic [C_INFL_W-1:0]         inflight_o,
  output logic [C_CNT_W-1:0]          fifo_count_o,
  output logic                        idle_o,
  output logic                        err_overflow_o
);

  localparam int                  c_ENTRY_W  = ADDR_WIDTH + ACCUM_DATA_WIDTH;
  localparam logic [C_INFL_W-1:0] c_INFL_ONE = C_INFL_W'(1);

  logic [ALU_LATENCY-1:0] r_dl_valid;
  logic [ADDR_WIDTH-1:0]  r_dl_addr [ALU_LATENCY];
  logic [C_INFL_W-1:0]    r_inflight;
  logic                   r_err_overflow;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_pop;
  logic                   w_fifo_valid;
  logic [C_CNT_W-1:0]     w_fifo_count;
  logic [c_ENTRY_W-1:0]   w_push_entry;
  logic [c_ENTRY_W-1:0]   w_head_entry;

  // Credit counts slots still inside the ALU so a non-stalling ALU never overruns the buffer.
  assign issue_ready_o = (32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);
  assign w_accept      = issue_valid_i && issue_ready_o;
  assign w_capture     = r_dl_valid[ALU_LATENCY-1];
  assign w_pop         = w_fifo_valid && wr_ready_i;
  assign w_push_entry  = {r_dl_addr[ALU_LATENCY-1], alu_data_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_valid <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) begin
        r_dl_addr[i] <= '0;
      end
    end else begin
      r_dl_valid[0] <= w_accept;
      r_dl_addr[0]  <= issue_addr_i;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_addr[i]  <= r_dl_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight     <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_accept && !w_capture) begin
        r_inflight <= r_inflight + c_INFL_ONE;
      end else if (!w_accept && w_capture) begin
        r_inflight <= r_inflight - c_INFL_ONE;
      end
      if (issue_valid_i && !issue_ready_o) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  fp7_result_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_capture),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .rd_data   (w_head_entry),
    .rd_valid  (w_fifo_valid),
    .count     (w_fifo_count)
  );

  assign wr_valid_o              = w_fifo_valid;
  assign {wr_addr_o, wr_data_o}  = w_head_entry;
  assign inflight_o              = r_inflight;
  assign fifo_count_o            = w_fifo_count;
  assign idle_o                  = (r_inflight == '0) && (w_fifo_count == '0);
  assign err_overflow_o          = r_err_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fp7_alu_result_sink.sv
// ----------------------------------------------------------------------------
// tb_fp7_alu_result_sink : scoreboard bench for fp7_alu_result_sink
// Revision               : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fp7_alu_result_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic [7:0]  issue_addr_i = 8'h00;
  logic [31:0] issue_data = 32'h0;
  logic        issue_ready_o;
  logic [31:0] alu_data_i;
  logic        wr_valid_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        wr_ready_i = 1'b0;
  logic [2:0]  inflight_o;
  logic [3:0]  fifo_count_o;
  logic        idle_o;
  logic        err_overflow_o;

  logic        wr_ready_fixed = 1'b1;
  logic        rand_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0]  m_pv;
  int          m_infl;
  int          m_cnt;
  logic        m_err;
  logic        m_credit;
  logic        m_acc;
  logic        m_cap;
  logic        m_pop;
  logic [39:0] exp_q [$];
  logic [31:0] alu_d [4];

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;

  fp7_alu_result_sink #(
    .ACCUM_DATA_WIDTH (32),
    .ADDR_WIDTH       (8),
    .ALU_LATENCY      (4),
    .FIFO_DEPTH       (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_addr_i   (issue_addr_i),
    .issue_ready_o  (issue_ready_o),
    .alu_data_i     (alu_data_i),
    .wr_valid_o     (wr_valid_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .wr_ready_i     (wr_ready_i),
    .inflight_o     (inflight_o),
    .fifo_count_o   (fifo_count_o),
    .idle_o         (idle_o),
    .err_overflow_o (err_overflow_o)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    wr_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : wr_ready_fixed;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  assign m_credit   = (m_cnt + m_infl) < 8;
  assign m_acc      = issue_valid_i && m_credit;
  assign m_cap      = m_pv[3];
  assign m_pop      = (m_cnt != 0) && wr_ready_i;
  assign alu_data_i = alu_d[3];

  // ALU pipeline keeps flowing through reset, so stale words still appear.
  always @(posedge clk) begin
    alu_d[0] <= issue_valid_i ? issue_data : 32'hBAD0BAD0;
    alu_d[1] <= alu_d[0];
    alu_d[2] <= alu_d[1];
    alu_d[3] <= alu_d[2];
    if (rst) begin
      m_pv   <= 4'b0;
      m_infl <= 0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
      exp_q.delete();
    end else begin
      m_pv   <= {m_pv[2:0], m_acc};
      m_infl <= m_infl + int'(m_acc) - int'(m_cap);
      m_cnt  <= m_cnt + int'(m_cap) - int'(m_pop);
      if (issue_valid_i && !m_credit) m_err <= 1'b1;
      if (m_acc) exp_q.push_back({issue_addr_i, issue_data});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      check("issue_ready", issue_ready_o, m_credit);
      check("inflight", inflight_o, m_infl);
      check("fifo_count", fifo_count_o, m_cnt);
      check("wr_valid", wr_valid_o, m_cnt != 0);
      check("idle", idle_o, (m_infl == 0) && (m_cnt == 0));
      check("err_overflow", err_overflow_o, m_err);
      if (prev_stall) begin
        check("hold_addr", wr_addr_o, prev_addr);
        check("hold_data", wr_data_o, prev_data);
      end
      if (wr_valid_o && wr_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {wr_addr_o, wr_data_o}, 40'h0);
          check("unexpected_write_valid", 1'b1, 1'b0);
        end else begin
          check("wr_addr", wr_addr_o, exp_q[0][39:32]);
          check("wr_data", wr_data_o, exp_q[0][31:0]);
          void'(exp_q.pop_front());
        end
      end
      prev_stall <= wr_valid_o && !wr_ready_i;
      prev_addr  <= wr_addr_o;
      prev_data  <= wr_data_o;
    end
  end

  // Entered and left at posedge+1; holds valid until the model grants credit.
  task automatic issue_one(input logic [7:0] a, input logic [31:0] d, output int waited);
    waited = 0;
    while (!m_credit && waited < 1000) begin
      issue_valid_i = 1'b0;
      @(posedge clk);
      #1;
      waited++;
    end
    check("credit_wait_bound", waited < 1000, 1'b1);
    issue_valid_i = 1'b1;
    issue_addr_i  = a;
    issue_data    = d;
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 400 && !(exp_q.size() == 0 && m_cnt == 0 && m_infl == 0); k++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int w;
    int total_wait;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", issue_ready_o, 1'b1);
    check("reset_wr_valid", wr_valid_o, 1'b0);
    check("reset_idle", idle_o, 1'b1);
    check("reset_wr_data", {wr_addr_o, wr_data_o}, 40'h0);
    repeat (5) @(posedge clk);
    #1;

    // Single issue: result presented five cycles after the issue cycle
    issue_one(8'h05, 32'h3F800000, w);
    repeat (3) @(posedge clk);
    #1;
    check("single_not_yet", wr_valid_o, 1'b0);
    @(posedge clk);
    #1;
    check("single_valid", wr_valid_o, 1'b1);
    check("single_addr", wr_addr_o, 8'h05);
    check("single_data", wr_data_o, 32'h3F800000);
    @(posedge clk);
    #1;
    check("single_idle_after", idle_o, 1'b1);

    // Back-to-back issues with a ready sink never wait for credit
    total_wait = 0;
    for (int i = 0; i < 20; i++) begin
      issue_one(8'(i), 32'h4000_0000 + 32'(i * 17), w);
      total_wait += w;
    end
    check("b2b_no_stall", total_wait, 0);
    wait_idle("b2b");

    // Stalled sink: exactly eight accepted, credit then withdrawn
    wr_ready_fixed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_one(8'h80 + 8'(i), 32'hC000_0000 | 32'(i), w);
    end
    repeat (6) @(posedge clk);
    #1;
    check("stall_count_full", fifo_count_o, 4'd8);
    check("stall_ready_low", issue_ready_o, 1'b0);
    check("stall_no_err", err_overflow_o, 1'b0);

    // Forced issue without credit is dropped and flagged
    issue_addr_i  = 8'hEE;
    issue_data    = 32'hDEADDEAD;
    issue_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    check("force_err", err_overflow_o, 1'b1);
    check("force_count", fifo_count_o, 4'd8);
    wr_ready_fixed = 1'b1;
    wait_idle("force");
    check("force_err_sticky", err_overflow_o, 1'b1);

    // Reset with 3 in flight and 5 buffered
    wr_ready_fixed = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      issue_one(8'h40 + 8'(i), 32'h1234_0000 | 32'(i), w);
    end
    @(posedge clk);
    #1;
    check("pre_rst_inflight", inflight_o, 3'd3);
    check("pre_rst_count", fifo_count_o, 4'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_valid", wr_valid_o, 1'b0);
    check("post_rst_inflight", inflight_o, 3'd0);
    check("post_rst_count", fifo_count_o, 4'd0);
    check("post_rst_ready", issue_ready_o, 1'b1);
    check("post_rst_err", err_overflow_o, 1'b0);
    wr_ready_fixed = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_write", exp_q.size(), 0);

    // Random sink readiness with random issues
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue_one(8'($urandom_range(0, 255)), $urandom, w);
    end
    rand_ready = 1'b0;
    wr_ready_fixed = 1'b1;
    wait_idle("random");
    check("final_idle", idle_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
